pi_estimator_multilane: RTL and testbench

//  Parametrised Monte Carlo pi estimator. LANES = 2**LANES_LOG2 independent 32-bit LFSR lanes each

---
 rtl/pi_estimator_multilane_if.sv | 23 ++
 rtl/pi_estimator_multilane.sv | 168 ++++++++++++++++
 tb/tb_pi_estimator_multilane.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pi_estimator_multilane_if.sv
// Control/status bundle between the PS register block and the pi estimator.
// The master drives the run controls; the slave returns status and the hit count.
interface pi_estimator_multilane_if #(
    parameter int unsigned CNT_W = 19
);
    logic             start;
    logic             abort;
    logic             enable;
    logic [31:0]      seed;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] hit_count;

    modport master (
        output start, abort, enable, seed,
        input  busy, done, hit_count
    );

    modport slave (
        input  start, abort, enable, seed,
        output busy, done, hit_count
    );
endinterface

// File: rtl/pi_estimator_multilane.sv
// Multi-lane Monte Carlo pi estimator: per-lane Galois LFSRs feed a 3-stage
// quarter-circle test whose per-cycle hit popcount is accumulated over a fixed batch.
module pi_estimator_multilane #(
    parameter int unsigned LANES_LOG2   = 2,
    parameter int unsigned COORD_W      = 16,
    parameter int unsigned SAMPLES_LOG2 = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    pi_estimator_multilane_if.slave  bus
);
    localparam int unsigned LANES  = 2 ** LANES_LOG2;
    localparam int unsigned CNT_W  = SAMPLES_LOG2 + LANES_LOG2 + 1;
    localparam int unsigned SQ_W   = 2 * COORD_W;
    localparam int unsigned POP_W  = LANES_LOG2 + 1;
    localparam int unsigned SCNT_W = SAMPLES_LOG2 + 1;

    localparam logic [SCNT_W-1:0] N_LAST    = SCNT_W'((1 << SAMPLES_LOG2) - 1);
    localparam logic [31:0]       LFSR_MASK = 32'h8020_0003;
    localparam logic [31:0]       GOLDEN    = 32'h9E37_79B9;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEED  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e              state_q;
    logic                busy_q;
    logic                done_q;
    logic [31:0]         seed_q;
    logic [SCNT_W-1:0]   scnt_q;
    logic [1:0]          drain_q;

    logic                issue_c;
    logic [LANES-1:0]    hit_c;
    logic [POP_W-1:0]    pop_c;

    logic                v1_q;
    logic                v2_q;
    logic [POP_W-1:0]    pop_q;
    logic [CNT_W-1:0]    hit_count_q;

    assign issue_c = (state_q == S_RUN) && bus.enable;

    // Run control; abort shares the reset path and wins over start.
    always_ff @(posedge clk) begin
        if (reset || bus.abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            scnt_q  <= '0;
            drain_q <= '0;
            if (reset) begin
                seed_q <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state_q <= S_SEED;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        seed_q  <= bus.seed;
                    end
                end
                S_SEED: begin
                    state_q <= S_RUN;
                    scnt_q  <= '0;
                end
                S_RUN: begin
                    if (bus.enable) begin
                        scnt_q <= scnt_q + SCNT_W'(1);
                        if (scnt_q == N_LAST) begin
                            state_q <= S_DRAIN;
                            drain_q <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    drain_q <= drain_q + 2'(1);
                    if (drain_q == 2'd2) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam logic [31:0] LANE_K = GOLDEN * 32'(i);

        logic [31:0]        lfsr_q;
        logic [31:0]        lane_seed_c;
        logic [COORD_W-1:0] x_c;
        logic [COORD_W-1:0] y_c;
        logic [SQ_W-1:0]    xx_q;
        logic [SQ_W-1:0]    yy_q;
        logic [SQ_W:0]      sum_c;

        assign lane_seed_c = seed_q ^ LANE_K;
        assign x_c         = lfsr_q[31 -: COORD_W];
        assign y_c         = lfsr_q[15 -: COORD_W];

        // Zero is the LFSR lock-up state, so a zero lane seed is replaced by 1.
        always_ff @(posedge clk) begin
            if (reset) begin
                lfsr_q <= '0;
            end else if (state_q == S_SEED) begin
                lfsr_q <= (lane_seed_c == 32'd0) ? 32'd1 : lane_seed_c;
            end else if (issue_c) begin
                lfsr_q <= lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                xx_q <= '0;
                yy_q <= '0;
            end else begin
                xx_q <= SQ_W'(x_c) * SQ_W'(x_c);
                yy_q <= SQ_W'(y_c) * SQ_W'(y_c);
            end
        end

        assign sum_c    = {1'b0, xx_q} + {1'b0, yy_q};
        assign hit_c[i] = ~sum_c[SQ_W];
    end

    always_comb begin
        pop_c = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            pop_c = pop_c + POP_W'(hit_c[l]);
        end
    end

    // Valid bits track issued samples through the square, popcount and accumulate stages.
    always_ff @(posedge clk) begin
        if (reset || bus.abort) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            pop_q       <= '0;
            hit_count_q <= '0;
        end else begin
            v1_q  <= issue_c;
            v2_q  <= v1_q;
            pop_q <= pop_c;
            if (state_q == S_SEED) begin
                hit_count_q <= '0;
            end else if (v2_q) begin
                hit_count_q <= hit_count_q + CNT_W'(pop_q);
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.hit_count = hit_count_q;
endmodule

// File: tb/tb_pi_estimator_multilane.sv
// Bench for pi_estimator_multilane: a small single-lane instance is checked every cycle
// against a timeline/arithmetic model; a default-sized instance runs the full-length batch.
module tb_pi_estimator_multilane;
    localparam int NA = 16;     // samples per run on the small instance
    localparam int NB = 65536;  // samples per lane on the default instance

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pi_estimator_multilane_if #(.CNT_W(5))  ifa ();
    pi_estimator_multilane_if #(.CNT_W(19)) ifb ();

    pi_estimator_multilane #(.LANES_LOG2(0), .COORD_W(16), .SAMPLES_LOG2(4)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa)
    );
    pi_estimator_multilane dut_b (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    function automatic logic [31:0] lane_seed(input logic [31:0] sd, input int lane);
        logic [31:0] g;
        logic [31:0] s;
        g = 32'h9E37_79B9;
        s = sd ^ 32'(g * 32'(lane));
        return (s == 32'd0) ? 32'd1 : s;
    endfunction

    function automatic bit in_circle(input longint x, input longint y, input int cw);
        return (x * x + y * y) < (64'sd1 << (2 * cw));
    endfunction

    // Reference hit total: plain loop over lanes and samples.
    function automatic int ref_hits(input logic [31:0] sd, input int ll2, input int cw, input int n);
        int h;
        logic [31:0] s;
        longint x, y, msk;
        h = 0;
        msk = (64'sd1 << cw) - 1;
        for (int lane = 0; lane < (1 << ll2); lane++) begin
            s = lane_seed(sd, lane);
            for (int k = 0; k < n; k++) begin
                x = longint'(s >> (32 - cw)) & msk;
                y = longint'(s >> (16 - cw)) & msk;
                if (in_circle(x, y, cw)) h++;
                s = lfsr_step(s);
            end
        end
        return h;
    endfunction

    // Timeline model of the small instance: 1 seed cycle, NA enabled issues, 3 drain cycles.
    bit m_active = 1'b0;
    bit m_seeded = 1'b0;
    bit m_done   = 1'b0;
    int m_issued = 0;
    int m_drain  = 0;
    int m_hits   = 0;
    int m_final  = 0;

    always @(posedge clk) begin
        if (reset || ifa.abort) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_hits   = 0;
        end else if (m_active) begin
            if (!m_seeded) m_seeded = 1'b1;
            else if (m_issued < NA) begin
                if (ifa.enable) m_issued++;
            end else begin
                m_drain++;
                if (m_drain == 3) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                    m_hits   = m_final;
                end
            end
        end else if (ifa.start) begin
            m_active = 1'b1;
            m_seeded = 1'b0;
            m_issued = 0;
            m_drain  = 0;
            m_done   = 1'b0;
            m_final  = ref_hits(ifa.seed, 0, 16, NA);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("cyc_busy", longint'(ifa.busy), longint'(m_active));
            chk("cyc_done", longint'(ifa.done), longint'(m_done));
            if (!m_active) chk("cyc_hit_count", longint'(ifa.hit_count), longint'(m_hits));
        end
    end

    // One run on the small instance; lat = negedges from start drive to done (0 if aborted, -1 on timeout).
    task automatic do_run(input logic [31:0] sd, input int p_lo, input int p_hi,
                          input int ab_at, input int sp_at, output int lat);
        lat = -1;
        @(negedge clk);
        ifa.seed   = sd;
        ifa.start  = 1'b1;
        ifa.enable = 1'b1;
        for (int j = 1; j <= 200; j++) begin
            @(negedge clk);
            if (ifa.done) begin
                lat = j;
                break;
            end
            if (ab_at > 0 && j == ab_at + 1) begin
                ifa.abort = 1'b0;
                lat = 0;
                break;
            end
            ifa.start  = (j == sp_at);
            ifa.enable = !((j - 1) >= p_lo && (j - 1) <= p_hi);
            ifa.abort  = (j == ab_at);
        end
        ifa.start  = 1'b0;
        ifa.enable = 1'b1;
        ifa.abort  = 1'b0;
    endtask

    initial begin
        int lat, h2, hb, p_lo, p_len, ab, sp;
        logic [31:0] sd;

        ifa.start = 1'b1; ifa.abort = 1'b0; ifa.enable = 1'b1; ifa.seed = 32'h1234_5678;
        ifb.start = 1'b1; ifb.abort = 1'b0; ifb.enable = 1'b1; ifb.seed = 32'h1234_5678;

        // Hand-computed pins for the model's building blocks.
        chk("pin_lfsr_1", longint'(lfsr_step(32'h1)), longint'(32'h8020_0003));
        chk("pin_lfsr_2", longint'(lfsr_step(32'h2)), 1);
        chk("pin_seed0_lane0", longint'(lane_seed(32'h0, 0)), 1);
        chk("pin_seed0_lane1", longint'(lane_seed(32'h0, 1)), longint'(32'h9E37_79B9));
        chk("pin_seed0_lane2", longint'(lane_seed(32'h0, 2)), longint'(32'h3C6E_F372));
        chk("pin_circle_edge", longint'(in_circle(65535, 0, 16)), 1);
        chk("pin_circle_in", longint'(in_circle(46340, 46340, 16)), 1);
        chk("pin_circle_out", longint'(in_circle(46341, 46341, 16)), 0);

        // Reset for 2 cycles with start held high.
        repeat (2) @(negedge clk);
        chk("rst_busy_a", longint'(ifa.busy), 0);
        chk("rst_done_a", longint'(ifa.done), 0);
        chk("rst_hit_a", longint'(ifa.hit_count), 0);
        chk("rst_busy_b", longint'(ifb.busy), 0);
        chk("rst_hit_b", longint'(ifb.hit_count), 0);
        reset = 1'b0;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        @(negedge clk);
        chk("post_rst_busy_a", longint'(ifa.busy), 0);
        chk("post_rst_busy_b", longint'(ifb.busy), 0);

        // Basic run.
        do_run(32'h1234_5678, -1, -2, 0, 0, lat);
        chk("t2_latency", lat, NA + 5);
        h2 = ref_hits(32'h1234_5678, 0, 16, NA);
        chk("t2_hits", longint'(ifa.hit_count), h2);

        // Pause for RUN cycles 3..7.
        do_run(32'h1234_5678, 3, 7, 0, 0, lat);
        chk("t4_latency", lat, NA + 10);
        chk("t4_hits", longint'(ifa.hit_count), h2);

        // enable low during SEED is ignored.
        do_run(32'h1234_5678, 0, 0, 0, 0, lat);
        chk("seed_en_latency", lat, NA + 5);

        // Abort at RUN cycle 10, then rerun.
        do_run(32'h1234_5678, -1, -2, 11, 0, lat);
        chk("t5_abort_ret", lat, 0);
        chk("t5_busy", longint'(ifa.busy), 0);
        chk("t5_done", longint'(ifa.done), 0);
        chk("t5_hit", longint'(ifa.hit_count), 0);
        do_run(32'h1234_5678, -1, -2, 0, 0, lat);
        chk("t5_rerun_latency", lat, NA + 5);
        chk("t5_rerun_hits", longint'(ifa.hit_count), h2);

        // start and abort together stay in IDLE.
        @(negedge clk);
        ifa.start = 1'b1; ifa.abort = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0; ifa.abort = 1'b0;
        chk("t5_sa_busy", longint'(ifa.busy), 0);
        @(negedge clk);
        chk("t5_sa_busy2", longint'(ifa.busy), 0);
        chk("t5_sa_hit", longint'(ifa.hit_count), 0);

        // Zero seed plus a start pulse mid-RUN.
        do_run(32'h0, -1, -2, 0, 8, lat);
        chk("t6_latency", lat, NA + 5);
        chk("t6_hits", longint'(ifa.hit_count), ref_hits(32'h0, 0, 16, NA));

        // Randomized runs: random seed, pause window, stray start, occasional abort.
        for (int r = 0; r < 12; r++) begin
            sd    = $urandom;
            p_lo  = int'($urandom_range(1, 12));
            p_len = int'($urandom_range(0, 5));
            sp    = int'($urandom_range(2, 15));
            ab    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 20)) : 0;
            do_run(sd, p_lo, p_lo + p_len - 1, ab, sp, lat);
            if (ab > 0) begin
                chk("rnd_abort_ret", lat, 0);
            end else begin
                chk("rnd_latency", lat, NA + 5 + p_len);
                chk("rnd_hits", longint'(ifa.hit_count), ref_hits(sd, 0, 16, NA));
            end
        end

        // Full-length default batch.
        @(negedge clk);
        ifb.seed = 32'hACE1_0001;
        ifb.start = 1'b1;
        lat = -1;
        for (int j = 1; j <= 70000; j++) begin
            @(negedge clk);
            ifb.start = 1'b0;
            if (ifb.done) begin
                lat = j;
                break;
            end
        end
        chk("t3_latency", lat, NB + 5);
        hb = ref_hits(32'hACE1_0001, 2, 16, NB);
        chk("t3_hits_model", longint'(ifb.hit_count), hb);
        chk("t3_pi_range", longint'(ifb.hit_count >= 19'd204800 && ifb.hit_count <= 19'd206980), 1);
        @(negedge clk);
        chk("t3_done_hold", longint'(ifb.done), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
